// File: rtl/sram_burst_ctrl_pkg.sv
// Shared types and sizing for the SRAM burst controller.
// FSM state encoding, skid depth and default bus widths.
package sram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;
  localparam int SKID_DEPTH     = 2;
  localparam int SKID_CNT_W     = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Command, write-stream, read-stream and SRAM-side signals of the burst controller.
// slave = controller side, master = initiator/SRAM environment side.
interface sram_burst_ctrl_if #(
  parameter int DATA_WIDTH = sram_burst_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = sram_burst_pkg::DEF_ADDR_WIDTH
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic                  busy;
  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, sram_dout,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, sram_en, sram_we, sram_addr, sram_din
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, sram_dout,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, sram_en, sram_we, sram_addr, sram_din
  );
endinterface

// File: rtl/sram_burst_ctrl_rd_skid.sv
// Two-entry FIFO catching SRAM read returns so read beats survive consumer backpressure.
// Output data reads as zero while empty.
module sram_rd_skid
  import sram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_dat,
  input  logic                  i_pop,
  output logic [SKID_CNT_W-1:0] o_count,
  output logic [DATA_WIDTH-1:0] o_dat,
  output logic                  o_vld
);
  logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [SKID_CNT_W-1:0] r_count;
  logic                  w_pop;

  assign w_pop   = i_pop && (r_count != '0);
  assign o_count = r_count;
  assign o_vld   = (r_count != '0);
  assign o_dat   = o_vld ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {{(SKID_CNT_W-1){1'b0}}, i_push} - {{(SKID_CNT_W-1){1'b0}}, w_pop};
    end
  end
endmodule

// File: rtl/sram_burst_ctrl.sv
// Burst controller for a single-port synchronous SRAM: one write or read burst at a time.
// Writes stream straight to the SRAM; reads return through a 2-entry skid buffer.
module sram_burst_ctrl
  import sram_burst_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  sram_burst_ctrl_if.slave bus
);
  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_rem;
  logic                    r_inflight;
  logic [SKID_CNT_W-1:0]   w_skid_cnt;
  logic [DATA_WIDTH-1:0]   w_skid_dat;
  logic                    w_skid_vld;
  logic                    w_pop;
  logic                    w_issue;
  logic                    w_wr_beat;
  logic [SKID_CNT_W:0]     w_occ;

  // Only issue a read when the skid buffer is guaranteed room for its return.
  assign w_pop     = w_skid_vld && bus.rd_ready;
  assign w_occ     = {1'b0, w_skid_cnt} + {{SKID_CNT_W{1'b0}}, r_inflight}
                   - {{SKID_CNT_W{1'b0}}, w_pop};
  assign w_issue   = (r_state == READ) && (w_occ < (SKID_CNT_W+1)'(SKID_DEPTH));
  assign w_wr_beat = (r_state == WRITE) && bus.wr_valid;

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.wr_ready  = (r_state == WRITE);
  assign bus.sram_en   = w_wr_beat || w_issue;
  assign bus.sram_we   = w_wr_beat;
  assign bus.sram_addr = ((r_state == WRITE) || (r_state == READ)) ? r_addr : '0;
  assign bus.sram_din  = (r_state == WRITE) ? bus.wr_data : '0;
  assign bus.rd_data   = w_skid_dat;
  assign bus.rd_valid  = w_skid_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_rem      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_addr  <= bus.cmd_addr;
            r_rem   <= bus.cmd_len;
            r_state <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (w_wr_beat) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
            if (r_rem == '0) r_state <= IDLE;
          end
        end
        READ: begin
          if (w_issue) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
            if (r_rem == '0) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!r_inflight && (w_skid_cnt == '0)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sram_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_rd_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (r_inflight),
    .i_push_dat (bus.sram_dout),
    .i_pop      (w_pop),
    .o_count    (w_skid_cnt),
    .o_dat      (w_skid_dat),
    .o_vld      (w_skid_vld)
  );
endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
- Initiator-side controller for the team's single-port synchronous `sram`. It drives the `sram` ports `en`, `we`, `addr` and `din`, and captures `dout`.
- Accepts one burst command at a time: write or read, a start address, and a beat count.
- For writes, it streams data in over a valid/ready port into consecutive SRAM words.
- For reads, it streams words out over a valid/ready port and handles backpressure without losing data.

Parameters:
- DATA_WIDTH, 8, SRAM word width
- ADDR_WIDTH, 4, SRAM address width; depth is 2**ADDR_WIDTH

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  controller can accept a command
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_addr  input  ADDR_WIDTH  start address
- cmd_len  input  ADDR_WIDTH  number of beats minus 1 (range 1..2**ADDR_WIDTH beats)
- wr_data  input  DATA_WIDTH  write beat data
- wr_valid  input  1  write beat offered
- wr_ready  output  1  write beat accepted when high with wr_valid
- rd_data  output  DATA_WIDTH  read beat data
- rd_valid  output  1  read beat present
- rd_ready  input  1  consumer accepts read beat
- busy  output  1  burst in progress (state != IDLE)
- sram_en  output  1  to sram en
- sram_we  output  1  to sram we
- sram_addr  output  ADDR_WIDTH  to sram addr
- sram_din  output  DATA_WIDTH  to sram din
- sram_dout  input  DATA_WIDTH  from sram dout; registered, valid 1 cycle after an en=1, we=0 edge

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; address and beat counters cleared.
  - Skid buffer emptied; in-flight flag cleared.
  - sram_en=0, sram_we=0, wr_ready=0, rd_valid=0, busy=0.
  - cmd_ready=1 while in IDLE, including during and immediately after reset.
  - rd_data=0 and sram_addr=0 while idle.
- The FSM has four states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch cur_addr=cmd_addr and remaining=cmd_len, then go to WRITE if cmd_write, otherwise READ.
  - No SRAM access occurs in the acceptance cycle.
- WRITE:
  - wr_ready=1.
  - SRAM outputs are combinational: sram_en=sram_we=wr_valid, sram_addr=cur_addr, sram_din=wr_data.
  - Each accepted beat writes at that clock edge, then cur_addr+1 (mod 2**ADDR_WIDTH) and remaining-1.
  - Accepting the beat with remaining==0 returns to IDLE.
  - Gaps in wr_valid stall the burst with no SRAM access.
- READ:
  - issue = (buf_count + inflight − pop) < 2, where pop=rd_valid&&rd_ready.
  - When issue is true: sram_en=1, sram_we=0, sram_addr=cur_addr; cur_addr advances and remaining decrements.
  - inflight is set for the following cycle, whose sram_dout is pushed into the skid buffer.
  - Issuing with remaining==0 moves to DRAIN.
- DRAIN:
  - No SRAM access.
  - Go to IDLE once inflight==0 and the buffer is empty.
- Read throughput:
  - With rd_ready held high: first rd_valid 2 cycles after the first issue, then 1 beat per cycle.
  - Under backpressure, rd_data and rd_valid hold stable until accepted. No beat is dropped or duplicated, and beats keep address order.
- Wrap-around: addresses wrap from 2**ADDR_WIDTH−1 to 0. A full-depth burst (cmd_len=all ones) is legal.
- Port gating:
  - wr_valid outside WRITE is ignored (wr_ready=0).
  - rd_ready with rd_valid=0 has no effect.
  - A new command is never accepted while busy.
- Mid-burst reset: aborts immediately. sram_en drops asynchronously, partial writes already committed remain, and buffered read data is discarded.

Decomposition:
- Package sram_burst_pkg holds:
  - state enum (IDLE, WRITE, READ, DRAIN);
  - SKID_DEPTH=2;
  - localparam DEPTH=2**ADDR_WIDTH.
- Sub-module sram_rd_skid holds the read-return path: a 2-entry FIFO with push, pop, count, data and valid; reset clears it.

Test Plan:
1. Write burst: cmd_write=1, addr=3, len=1, beats A5 then 3C with wr_valid continuous -> SRAM writes A5@3 and 3C@4 on consecutive edges; controller returns to IDLE the cycle after the second beat.
2. Read burst: read addr=3, len=1 with rd_ready=1 -> rd_data A5 then 3C on consecutive cycles, first one 2 cycles after the first sram_en; busy deasserts after the last beat is accepted.
3. Backpressure: read 4 beats with rd_ready low for 3 cycles after the first rd_valid -> rd_data holds stable; issue count never exceeds buffer space; all 4 words arrive in order with none lost.
4. Wrap-around: write addr=E, len=3 with data 11,22,33,44, then read back -> SRAM addresses E,F,0,1 in that order; read returns 11,22,33,44.
5. Write gaps: wr_valid toggles 1,0,0,1 -> sram_en pulses only on valid cycles; address advances by exactly one per accepted beat.
6. Reset mid-read: assert rst_n=0 during READ with buffer full -> rd_valid=0 and sram_en=0 immediately; cmd_ready=1 after release; a new command is accepted normally.
